cfg_frame_loader: RTL and testbench
===================================

// Module: cfg_frame_loader
// PURPOSE
//  Configuration sequencer for the pcbfpga fabric. Parses a byte-stream bitstream
//  and writes one config frame (LUT INIT / IOB mode bits) per tile address.
//  Holds GLOBAL_EN low until a checksum-verified load completes, so IOB outputs
//  and DFFs stay inert during configuration. Sits between the host/SPI byte
//  source and the fabric configuration write port.
// PARAMETERS
//  FRAME_BITS  16     config bits per frame; multiple of 8, range 8..64 (16 = K=4 LUT INIT)
//  ADDR_W      6      config address width, 1..8
//  SYNC_BYTE   8'hA5  sync marker that starts a bitstream
// PORTS
//  CLK            in   1           fabric clock, all state on rising edge
//  RST_N          in   1           asynchronous active-low reset
//  IN_DATA        in   8           bitstream byte
//  IN_VALID       in   1           IN_DATA valid
//  IN_READY       out  1           byte accepted when IN_VALID & IN_READY at CLK edge
//  RESTART        in   1           sync: return from DONE/ERROR to IDLE
//  CFG_ADDR       out  ADDR_W      frame write address
//  CFG_DATA       out  FRAME_BITS  frame write data
//  CFG_WE         out  1           one-cycle frame write strobe
//  GLOBAL_EN      out  1           fabric enable; high only in DONE
//  DONE           out  1           load complete, checksum good
//  ERROR          out  1           load failed (checksum mismatch or bad address)
//  FRAMES_LOADED  out  8           frames written since last IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; IN_READY=1; CFG_WE=0; CFG_ADDR=0; CFG_DATA=0; GLOBAL_EN=0;
//    DONE=0; ERROR=0; FRAMES_LOADED=0; checksum=0; frame counter=0.
//  - Stream format: SYNC_BYTE, N (frame count, 0..255), N x {ADDR byte,
//    FRAME_BITS/8 data bytes, LSB byte first}, CHK byte.
//    CHK = XOR of all bytes after SYNC and before CHK.
//  - States: IDLE, COUNT, ADDR, DATA, WRITE, CHECK, DONE, ERROR.
//  - IDLE: bytes != SYNC_BYTE are consumed and discarded. SYNC_BYTE -> COUNT;
//    clear checksum and FRAMES_LOADED.
//  - COUNT: latch N; XOR into checksum; N==0 -> CHECK, else -> ADDR.
//  - ADDR: if byte >= 2**ADDR_W -> ERROR (no write); else latch CFG_ADDR -> DATA.
//  - DATA: shift bytes into CFG_DATA at bit position 8*i; after byte FRAME_BITS/8-1 -> WRITE.
//  - WRITE: exactly one cycle; CFG_WE=1; CFG_ADDR/CFG_DATA stable; IN_READY=0;
//    FRAMES_LOADED++. Remaining frames>0 -> ADDR, else -> CHECK.
//  - Latency: CFG_WE rises the cycle after the last data byte is accepted.
//  - CHECK: compare byte to checksum; match -> DONE, else -> ERROR.
//    Flags assert the cycle after the CHK byte is accepted.
//  - Checksum accumulates every byte accepted in COUNT, ADDR and DATA.
//  - DONE: GLOBAL_EN=1, DONE=1. ERROR: ERROR=1, GLOBAL_EN=0.
//    In both, IN_READY=0 and CFG_WE=0.
//  - RESTART: taken only in DONE/ERROR; next cycle IDLE, and DONE, ERROR and
//    GLOBAL_EN clear. Ignored in all other states.
//  - Stalls: IN_VALID=0 holds state indefinitely; no timeout.
//  - Frames already written before an ERROR are not rolled back.
//    GLOBAL_EN stays 0 in that case.
//  - Duplicate addresses are written again; the last write wins at the fabric.
//  - FRAMES_LOADED saturates at 255; N<=255, so it never wraps.
//  - RST_N low at any time, including mid-frame or during WRITE: immediate return
//    to reset values. A partial frame is never strobed.
// TESTING
//  1. Reset then A5,01,03,34,12,24 (chk=01^03^34^12) -> one CFG_WE, ADDR=3, DATA=16'h1234;
//     DONE=1, GLOBAL_EN=1, FRAMES_LOADED=1.
//  2. Junk 00,FF,5A then A5,00,00 -> junk discarded, no CFG_WE, DONE=1 after the 3rd byte.
//  3. Valid 2-frame stream with CHK^8'h01 -> two CFG_WE, ERROR=1, GLOBAL_EN=0;
//     RESTART -> IDLE, flags clear.
//  4. ADDR_W=6, stream A5,01,40,... -> ERROR the cycle after 8'h40 is accepted, no CFG_WE.
//  5. IN_VALID toggled randomly over a 255-frame stream -> IN_READY=0 on exactly the
//     255 WRITE cycles; FRAMES_LOADED=255; DONE=1.
//  6. RST_N pulsed low after the first data byte -> all outputs reset immediately,
//     no CFG_WE; a fresh stream then loads normally.

Source files
------------

// File: rtl/cfg_frame_loader_if.sv
// Byte-stream input and fabric config-write bundle for cfg_frame_loader.
// The host/SPI source uses master; the loader uses slave.
interface cfg_frame_loader_if #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned ADDR_W     = 6
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  restart;
   logic [ADDR_W-1:0]     cfg_addr;
   logic [FRAME_BITS-1:0] cfg_data;
   logic                  cfg_we;
   logic                  global_en;
   logic                  done;
   logic                  error;
   logic [7:0]            frames_loaded;

   modport master (
      output in_data, in_valid, restart,
      input  in_ready, cfg_addr, cfg_data, cfg_we, global_en, done, error, frames_loaded
   );

   modport slave (
      input  in_data, in_valid, restart,
      output in_ready, cfg_addr, cfg_data, cfg_we, global_en, done, error, frames_loaded
   );
endinterface

// File: rtl/cfg_frame_loader.sv
// Parses a sync-prefixed, XOR-checksummed byte stream into per-tile config frame writes.
// The fabric enable is only raised once the whole stream has checked good.
module cfg_frame_loader #(
   parameter int unsigned FRAME_BITS = 16,
   parameter int unsigned ADDR_W     = 6,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input logic              clk,
   input logic              rst_n,
   cfg_frame_loader_if.slave bus
);
   localparam int unsigned NumBytes = FRAME_BITS / 8;
   localparam int unsigned IdxW     = (NumBytes > 1) ? $clog2(NumBytes) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NumBytes - 1);

   typedef enum logic [2:0] {
      StIdle, StCount, StAddr, StData, StWrite, StCheck, StDone, StError
   } state_e;

   state_e                state_q, state_d;
   logic [7:0]            chk_q, chk_d;
   logic [7:0]            frames_left_q, frames_left_d;
   logic [7:0]            frames_loaded_q, frames_loaded_d;
   logic [IdxW-1:0]       idx_q, idx_d;
   logic [ADDR_W-1:0]     addr_q, addr_d;
   logic [FRAME_BITS-1:0] data_q, data_d;
   logic                  we_q, we_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic accept;
   logic addr_bad;

   assign accept   = bus.in_valid & ready_q;
   assign addr_bad = (32'(bus.in_data) >> ADDR_W) != 32'd0;

   always_comb begin
      state_d         = state_q;
      chk_d           = chk_q;
      frames_left_d   = frames_left_q;
      frames_loaded_d = frames_loaded_q;
      idx_d           = idx_q;
      addr_d          = addr_q;
      data_d          = data_q;
      we_d            = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (accept && bus.in_data == SYNC_BYTE) begin
               state_d         = StCount;
               chk_d           = 8'h00;
               frames_loaded_d = 8'h00;
            end
         end
         StCount: begin
            if (accept) begin
               chk_d         = chk_q ^ bus.in_data;
               frames_left_d = bus.in_data;
               state_d       = (bus.in_data == 8'h00) ? StCheck : StAddr;
            end
         end
         StAddr: begin
            if (accept) begin
               if (addr_bad) begin
                  state_d = StError;
               end else begin
                  chk_d   = chk_q ^ bus.in_data;
                  addr_d  = bus.in_data[ADDR_W-1:0];
                  idx_d   = '0;
                  state_d = StData;
               end
            end
         end
         StData: begin
            if (accept) begin
               chk_d                         = chk_q ^ bus.in_data;
               data_d[8*int'(idx_q) +: 8]    = bus.in_data;
               if (idx_q == LastIdx) begin
                  state_d = StWrite;
                  we_d    = 1'b1;
               end else begin
                  idx_d = IdxW'(idx_q + 1'b1);
               end
            end
         end
         StWrite: begin
            frames_left_d   = frames_left_q - 8'd1;
            frames_loaded_d = (frames_loaded_q == 8'hFF) ? 8'hFF : frames_loaded_q + 8'd1;
            state_d         = (frames_left_q == 8'd1) ? StCheck : StAddr;
         end
         StCheck: begin
            if (accept) begin
               state_d = (bus.in_data == chk_q) ? StDone : StError;
            end
         end
         StDone, StError: begin
            if (bus.restart) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
      // Outputs are registered off the next state so they line up with it.
      ready_d = !(state_d inside {StWrite, StDone, StError});
      done_d  = (state_d == StDone);
      error_d = (state_d == StError);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         chk_q           <= 8'h00;
         frames_left_q   <= 8'h00;
         frames_loaded_q <= 8'h00;
         idx_q           <= '0;
         addr_q          <= '0;
         data_q          <= '0;
         we_q            <= 1'b0;
         ready_q         <= 1'b1;
         done_q          <= 1'b0;
         error_q         <= 1'b0;
      end else begin
         state_q         <= state_d;
         chk_q           <= chk_d;
         frames_left_q   <= frames_left_d;
         frames_loaded_q <= frames_loaded_d;
         idx_q           <= idx_d;
         addr_q          <= addr_d;
         data_q          <= data_d;
         we_q            <= we_d;
         ready_q         <= ready_d;
         done_q          <= done_d;
         error_q         <= error_d;
      end
   end

   assign bus.in_ready      = ready_q;
   assign bus.cfg_addr      = addr_q;
   assign bus.cfg_data      = data_q;
   assign bus.cfg_we        = we_q;
   assign bus.global_en     = done_q;
   assign bus.done          = done_q;
   assign bus.error         = error_q;
   assign bus.frames_loaded = frames_loaded_q;
endmodule

// File: tb/tb_cfg_frame_loader.sv
// Directed bench for cfg_frame_loader: hand-computed streams, checksums and expected frame writes.
module tb_cfg_frame_loader;
   logic clk;
   logic rst_n;

   int checks = 0;
   int errors = 0;

   int we_cnt = 0;
   int ready_low_cnt = 0;
   int ready_we_clash = 0;
   logic [31:0] last_addr = 0;
   logic [31:0] last_data = 0;

   int we0, rl0, cl0;
   logic [7:0] sum;
   logic [7:0] b;
   logic [31:0] exp_addr, exp_data;

   cfg_frame_loader_if #(.FRAME_BITS(16), .ADDR_W(6)) bus ();

   cfg_frame_loader #(
      .FRAME_BITS(16),
      .ADDR_W(6),
      .SYNC_BYTE(8'hA5)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.cfg_we) begin
         we_cnt    <= we_cnt + 1;
         last_addr <= 32'(bus.cfg_addr);
         last_data <= 32'(bus.cfg_data);
      end
      if (rst_n && !bus.done && !bus.error) begin
         if (!bus.in_ready) ready_low_cnt <= ready_low_cnt + 1;
         if (bus.in_ready === bus.cfg_we) ready_we_clash <= ready_we_clash + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one byte and holds it until accepted; optional random idle gap first.
   task automatic send(input logic [7:0] d, input bit gap);
      int n;
      @(negedge clk);
      if (gap) begin
         bus.in_valid = 1'b0;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      n = 0;
      while (!bus.in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) begin
         errors++;
         $display("FAIL ready_timeout: observed in_ready low for %0d cycles, required < 100", n);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic do_restart();
      @(negedge clk);
      bus.restart = 1'b1;
      @(posedge clk);
      #1;
      bus.restart = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: observed simulation still running, required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n        = 1'b0;
      bus.in_data  = 8'h00;
      bus.in_valid = 1'b0;
      bus.restart  = 1'b0;
      #23;
      check("rst_ready", 32'(bus.in_ready), 1);
      check("rst_we", 32'(bus.cfg_we), 0);
      check("rst_flags", {29'd0, bus.done, bus.error, bus.global_en}, 0);
      check("rst_frames", 32'(bus.frames_loaded), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: single frame, addr 3, data 1234, chk 24
      we0 = we_cnt;
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h03, 0);
      send(8'h34, 0);
      check("t1_no_early_we", 32'(bus.cfg_we), 0);
      send(8'h12, 0);
      check("t1_we_latency", 32'(bus.cfg_we), 1);
      check("t1_ready_in_write", 32'(bus.in_ready), 0);
      check("t1_addr", 32'(bus.cfg_addr), 32'h3);
      check("t1_data", 32'(bus.cfg_data), 32'h1234);
      send(8'h24, 0);
      check("t1_done", 32'(bus.done), 1);
      check("t1_gen", 32'(bus.global_en), 1);
      check("t1_error", 32'(bus.error), 0);
      check("t1_frames", 32'(bus.frames_loaded), 1);
      check("t1_we_count", 32'(we_cnt - we0), 1);
      check("t1_ready_done", 32'(bus.in_ready), 0);
      do_restart();
      check("t1_restart_flags", {29'd0, bus.done, bus.error, bus.global_en}, 0);
      check("t1_restart_ready", 32'(bus.in_ready), 1);

      // 2: junk discarded, zero-frame stream
      we0 = we_cnt;
      send(8'h00, 0);
      send(8'hFF, 0);
      send(8'h5A, 0);
      send(8'hA5, 0);
      send(8'h00, 0);
      check("t2_not_done_yet", 32'(bus.done), 0);
      send(8'h00, 0);
      check("t2_done", 32'(bus.done), 1);
      check("t2_frames", 32'(bus.frames_loaded), 0);
      check("t2_no_we", 32'(we_cnt - we0), 0);
      do_restart();

      // 3: two frames, corrupted checksum (good chk = 94)
      we0 = we_cnt;
      send(8'hA5, 0);
      send(8'h02, 0);
      send(8'h05, 0);
      send(8'hEF, 0);
      send(8'hBE, 0);
      send(8'h3F, 0);
      send(8'h0D, 0);
      send(8'hF0, 0);
      send(8'h95, 0);
      check("t3_error", 32'(bus.error), 1);
      check("t3_done", 32'(bus.done), 0);
      check("t3_gen", 32'(bus.global_en), 0);
      check("t3_we_count", 32'(we_cnt - we0), 2);
      check("t3_last_addr", last_addr, 32'h3F);
      check("t3_last_data", last_data, 32'hF00D);
      check("t3_frames", 32'(bus.frames_loaded), 2);
      do_restart();
      check("t3_restart_error", 32'(bus.error), 0);
      check("t3_restart_ready", 32'(bus.in_ready), 1);

      // 4: address 40 is out of range for 6 address bits
      we0 = we_cnt;
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h40, 0);
      check("t4_error", 32'(bus.error), 1);
      check("t4_gen", 32'(bus.global_en), 0);
      check("t4_no_we", 32'(we_cnt - we0), 0);
      do_restart();

      // 5: 255 frames with random valid gaps
      we0 = we_cnt;
      rl0 = ready_low_cnt;
      cl0 = ready_we_clash;
      sum = 8'hFF;
      send(8'hA5, 1);
      send(8'hFF, 1);
      for (int i = 0; i < 255; i++) begin
         b = 8'(i);
         exp_addr = 32'(b & 8'h3F);
         exp_data = {16'd0, b ^ 8'h5A, b};
         sum = sum ^ (b & 8'h3F) ^ b ^ (b ^ 8'h5A);
         send(b & 8'h3F, 1);
         send(b, 1);
         send(b ^ 8'h5A, 1);
      end
      send(sum, 1);
      check("t5_done", 32'(bus.done), 1);
      check("t5_frames", 32'(bus.frames_loaded), 255);
      check("t5_we_count", 32'(we_cnt - we0), 255);
      check("t5_ready_low", 32'(ready_low_cnt - rl0), 255);
      check("t5_ready_we_align", 32'(ready_we_clash - cl0), 0);
      check("t5_last_addr", last_addr, exp_addr);
      check("t5_last_data", last_data, exp_data);
      do_restart();

      // 6: reset mid-frame, then a fresh load (chk 60)
      we0 = we_cnt;
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h07, 0);
      send(8'hCD, 0);
      rst_n = 1'b0;
      #1;
      check("t6_rst_ready", 32'(bus.in_ready), 1);
      check("t6_rst_addr", 32'(bus.cfg_addr), 0);
      check("t6_rst_data", 32'(bus.cfg_data), 0);
      check("t6_rst_we", 32'(bus.cfg_we), 0);
      repeat (3) @(negedge clk);
      check("t6_no_we", 32'(we_cnt - we0), 0);
      rst_n = 1'b1;
      send(8'hA5, 0);
      send(8'h01, 0);
      send(8'h07, 0);
      send(8'hCD, 0);
      send(8'hAB, 0);
      send(8'h60, 0);
      check("t6_done", 32'(bus.done), 1);
      check("t6_we_count", 32'(we_cnt - we0), 1);
      check("t6_last_addr", last_addr, 32'h7);
      check("t6_last_data", last_data, 32'hABCD);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
